// File: rtl/conv_pkg.sv
// Shared widths and result saturation limits for the convolution datapath.
// Used by the MAC stage and the pooling stage.
package conv_pkg;

  localparam int DATA_WIDTH_DEF      = 8;
  localparam int ACC_WIDTH_DEF       = 20;
  localparam int RSLT_DATA_WIDTH_DEF = 8;
  localparam int RSLT_ADDR_WIDTH_DEF = 8;
  localparam int SHIFT_WIDTH_DEF     = 4;
  localparam int CNT_WIDTH_DEF       = 16;

  // Largest and smallest values of a signed word that is 'width' bits wide.
  function automatic longint sat_max(input int width);
    return (longint'(1) <<< (width - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

  localparam longint RSLT_MAX_DEF = sat_max(RSLT_DATA_WIDTH_DEF);
  localparam longint RSLT_MIN_DEF = sat_min(RSLT_DATA_WIDTH_DEF);

endpackage

// File: rtl/conv_mac_if.sv
// Signal bundle between the AGU and memories on one side and conv_mac on the other.
// The master side drives taps and config. The slave side returns result writes and status.
interface conv_mac_if #(
  parameter int DATA_WIDTH      = conv_pkg::DATA_WIDTH_DEF,
  parameter int RSLT_DATA_WIDTH = conv_pkg::RSLT_DATA_WIDTH_DEF,
  parameter int RSLT_ADDR_WIDTH = conv_pkg::RSLT_ADDR_WIDTH_DEF,
  parameter int SHIFT_WIDTH     = conv_pkg::SHIFT_WIDTH_DEF,
  parameter int CNT_WIDTH       = conv_pkg::CNT_WIDTH_DEF
) ();

  logic                              start;
  logic                              in_valid;
  logic                              in_last;
  logic        [RSLT_ADDR_WIDTH-1:0] in_result_addr;
  logic signed [DATA_WIDTH-1:0]      img_data;
  logic signed [DATA_WIDTH-1:0]      kern_data;
  logic                              relu_en;
  logic        [SHIFT_WIDTH-1:0]     out_shift;

  logic                              rslt_we;
  logic        [RSLT_ADDR_WIDTH-1:0] rslt_addr;
  logic signed [RSLT_DATA_WIDTH-1:0] rslt_data;
  logic        [CNT_WIDTH-1:0]       rslt_count;
  logic                              busy;

  modport master (
    output start, in_valid, in_last, in_result_addr, img_data, kern_data, relu_en, out_shift,
    input  rslt_we, rslt_addr, rslt_data, rslt_count, busy
  );

  modport slave (
    input  start, in_valid, in_last, in_result_addr, img_data, kern_data, relu_en, out_shift,
    output rslt_we, rslt_addr, rslt_data, rslt_count, busy
  );

endinterface

// File: rtl/conv_post.sv
// Result post-processing: arithmetic right shift, optional ReLU, then saturation
// to the signed result width. Purely combinational.
module conv_post
  import conv_pkg::*;
#(
  parameter int ACC_WIDTH       = ACC_WIDTH_DEF,
  parameter int RSLT_DATA_WIDTH = RSLT_DATA_WIDTH_DEF,
  parameter int SHIFT_WIDTH     = SHIFT_WIDTH_DEF
) (
  input  logic signed [ACC_WIDTH-1:0]       sum,
  input  logic        [SHIFT_WIDTH-1:0]     shift,
  input  logic                              relu_en,
  output logic signed [RSLT_DATA_WIDTH-1:0] result
);

  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(sat_max(RSLT_DATA_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(sat_min(RSLT_DATA_WIDTH));

  logic signed [ACC_WIDTH-1:0] shifted;
  logic signed [ACC_WIDTH-1:0] clamped;

  always_comb begin
    shifted = sum >>> shift;
    clamped = (relu_en && shifted[ACC_WIDTH-1]) ? '0 : shifted;
    if (clamped > SAT_HI) begin
      result = SAT_HI[RSLT_DATA_WIDTH-1:0];
    end else if (clamped < SAT_LO) begin
      result = SAT_LO[RSLT_DATA_WIDTH-1:0];
    end else begin
      result = clamped[RSLT_DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/conv_mac.sv
// Convolution multiply-accumulate stage: registers AGU tap markers, multiplies the
// memory read data a cycle later, accumulates each window and writes one result.
module conv_mac
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH       = ACC_WIDTH_DEF,
  parameter int RSLT_DATA_WIDTH = RSLT_DATA_WIDTH_DEF,
  parameter int RSLT_ADDR_WIDTH = RSLT_ADDR_WIDTH_DEF,
  parameter int SHIFT_WIDTH     = SHIFT_WIDTH_DEF,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic       clk,
  input  logic       reset,
  conv_mac_if.slave  bus
);

  logic                              s1_valid_reg;
  logic                              s1_last_reg;
  logic        [RSLT_ADDR_WIDTH-1:0] s1_addr_reg;

  logic                              s2_valid_reg;
  logic                              s2_last_reg;
  logic        [RSLT_ADDR_WIDTH-1:0] s2_addr_reg;
  logic signed [ACC_WIDTH-1:0]       s2_prod_reg;

  logic signed [ACC_WIDTH-1:0]       acc_reg;
  logic                              first_reg;

  logic                              rslt_we_reg;
  logic        [RSLT_ADDR_WIDTH-1:0] rslt_addr_reg;
  logic signed [RSLT_DATA_WIDTH-1:0] rslt_data_reg;
  logic        [CNT_WIDTH-1:0]       rslt_count_reg;

  logic signed [2*DATA_WIDTH-1:0]    prod_full;
  logic signed [ACC_WIDTH-1:0]       prod_ext;
  logic signed [ACC_WIDTH-1:0]       acc_next;
  logic signed [RSLT_DATA_WIDTH-1:0] post_result;

  // Memory data arrives one cycle after the tap strobe, i.e. alongside S1.
  always_comb begin
    prod_full = bus.img_data * bus.kern_data;
    prod_ext  = ACC_WIDTH'(prod_full);
    acc_next  = (first_reg ? '0 : acc_reg) + s2_prod_reg;
  end

  conv_post #(
    .ACC_WIDTH       (ACC_WIDTH),
    .RSLT_DATA_WIDTH (RSLT_DATA_WIDTH),
    .SHIFT_WIDTH     (SHIFT_WIDTH)
  ) u_post (
    .sum     (acc_next),
    .shift   (bus.out_shift),
    .relu_en (bus.relu_en),
    .result  (post_result)
  );

  always_ff @(posedge clk) begin
    // start clears everything reset does; an in_valid coinciding with start is dropped.
    if (reset || bus.start) begin
      s1_valid_reg   <= 1'b0;
      s1_last_reg    <= 1'b0;
      s1_addr_reg    <= '0;
      s2_valid_reg   <= 1'b0;
      s2_last_reg    <= 1'b0;
      s2_addr_reg    <= '0;
      s2_prod_reg    <= '0;
      acc_reg        <= '0;
      first_reg      <= 1'b1;
      rslt_we_reg    <= 1'b0;
      rslt_addr_reg  <= '0;
      rslt_data_reg  <= '0;
      rslt_count_reg <= '0;
    end else begin
      s1_valid_reg <= bus.in_valid;
      s1_last_reg  <= bus.in_valid & bus.in_last;
      s1_addr_reg  <= bus.in_result_addr;

      s2_valid_reg <= s1_valid_reg;
      s2_last_reg  <= s1_last_reg;
      s2_addr_reg  <= s1_addr_reg;
      s2_prod_reg  <= prod_ext;

      // Bubbles leave the partial sum and first flag untouched.
      if (s2_valid_reg) begin
        acc_reg   <= acc_next;
        first_reg <= s2_last_reg;
      end

      rslt_we_reg <= s2_valid_reg & s2_last_reg;
      if (s2_valid_reg && s2_last_reg) begin
        rslt_addr_reg  <= s2_addr_reg;
        rslt_data_reg  <= post_result;
        rslt_count_reg <= rslt_count_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.rslt_we    = rslt_we_reg;
  assign bus.rslt_addr  = rslt_addr_reg;
  assign bus.rslt_data  = rslt_data_reg;
  assign bus.rslt_count = rslt_count_reg;
  assign bus.busy       = s1_valid_reg | s2_valid_reg | rslt_we_reg | ~first_reg;

endmodule

// File: tb/tb_conv_mac.sv
// Directed bench for conv_mac: a table of single windows with hand-computed results,
// plus sequences for back-to-back windows, single-tap bursts and mid-window aborts.
module tb_conv_mac;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_mac_if bus ();

  conv_mac dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    int                cyc;
    logic [7:0]        addr;
    logic signed [7:0] data;
    logic [15:0]       cnt;
  } wr_t;

  typedef struct packed {
    logic [2:0]       n;
    logic [3:0][7:0]  img;
    logic [3:0][7:0]  kern;
    logic [3:0][1:0]  gap;
    logic [7:0]       addr;
    logic             relu;
    logic [3:0]       shift;
    logic signed [7:0] exp;
  } vec_t;

  wr_t  wr_q[$];
  vec_t vecs[$];
  int   cyc;
  int   n_vec;
  int   n_err;
  logic signed [7:0] pend_img;
  logic signed [7:0] pend_kern;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.rslt_we === 1'b1) begin
      wr_q.push_back('{cyc, bus.rslt_addr, bus.rslt_data, bus.rslt_count});
      $display("write  cyc=%0d addr=%0d data=%0d count=%0d", cyc, bus.rslt_addr, bus.rslt_data, bus.rslt_count);
    end
  endtask

  // Memory read data for a tap shows up one cycle after its strobe.
  task automatic drive(input logic v, input logic l, input logic [7:0] a,
                       input logic signed [7:0] im, input logic signed [7:0] kn);
    bus.in_valid       = v;
    bus.in_last        = l;
    bus.in_result_addr = a;
    bus.img_data       = pend_img;
    bus.kern_data      = pend_kern;
    pend_img           = v ? im : 8'sd0;
    pend_kern          = v ? kn : 8'sd0;
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'd0, 8'sd0, 8'sd0);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    idle();
    bus.start = 1'b0;
  endtask

  function automatic void add_vec(input int n, input int i0, input int i1, input int i2, input int i3,
                                  input int k0, input int k1, input int k2, input int k3,
                                  input int g1, input int g2, input int g3,
                                  input int a, input int r, input int sh, input int e);
    vec_t v;
    v.n = 3'(n);
    v.img[0] = 8'(i0); v.img[1] = 8'(i1); v.img[2] = 8'(i2); v.img[3] = 8'(i3);
    v.kern[0] = 8'(k0); v.kern[1] = 8'(k1); v.kern[2] = 8'(k2); v.kern[3] = 8'(k3);
    v.gap[0] = 2'd0; v.gap[1] = 2'(g1); v.gap[2] = 2'(g2); v.gap[3] = 2'(g3);
    v.addr = 8'(a);
    v.relu = 1'(r);
    v.shift = 4'(sh);
    v.exp = 8'(e);
    vecs.push_back(v);
  endfunction

  task automatic run_window(input vec_t v, output int last_cyc);
    last_cyc = cyc;
    for (int i = 0; i < int'(v.n); i++) begin
      for (int g = 0; g < int'(v.gap[i]); g++) begin
        idle();
        check("busy_in_bubble", int'(bus.busy), 1);
      end
      last_cyc = cyc;
      drive(1'b1, (i == int'(v.n) - 1), v.addr, $signed(v.img[i]), $signed(v.kern[i]));
    end
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    int    last_cyc;
    string nm;
    nm = $sformatf("vec%0d", idx);
    bus.relu_en   = v.relu;
    bus.out_shift = v.shift;
    pulse_start();
    wr_q.delete();
    run_window(v, last_cyc);
    repeat (3) idle();
    check({nm, ".busy_after"}, int'(bus.busy), 0);
    repeat (2) idle();
    check({nm, ".nwrites"}, wr_q.size(), 1);
    if (wr_q.size() > 0) begin
      check({nm, ".latency"}, wr_q[0].cyc - last_cyc, 3);
      check({nm, ".addr"}, int'(wr_q[0].addr), int'(v.addr));
      check({nm, ".data"}, int'(wr_q[0].data), int'(v.exp));
      check({nm, ".count"}, int'(wr_q[0].cnt), 1);
    end
    check({nm, ".data_hold"}, int'(bus.rslt_data), int'(v.exp));
    $display("vector %0d done: addr=%0d expected data=%0d", idx, v.addr, v.exp);
  endtask

  initial begin
    int la;
    int lb;
    cyc = 0; n_vec = 0; n_err = 0;
    pend_img = 8'sd0; pend_kern = 8'sd0;
    reset = 1'b1;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_result_addr = 8'd0;
    bus.img_data = 8'sd0; bus.kern_data = 8'sd0; bus.relu_en = 1'b0; bus.out_shift = 4'd0;

    // Reset held two cycles with taps toggling, then one cycle after release.
    for (int i = 0; i < 2; i++) begin
      drive(i == 0, i == 0, 8'd3, 8'sd1, 8'sd1);
      check("reset.we", int'(bus.rslt_we), 0);
      check("reset.count", int'(bus.rslt_count), 0);
      check("reset.busy", int'(bus.busy), 0);
    end
    reset = 1'b0;
    idle();
    check("post_reset.we", int'(bus.rslt_we), 0);
    check("post_reset.count", int'(bus.rslt_count), 0);
    check("post_reset.busy", int'(bus.busy), 0);
    check("post_reset.addr", int'(bus.rslt_addr), 0);
    check("post_reset.data", int'(bus.rslt_data), 0);

    //       n  img                 kern                  gaps    addr relu sh  exp
    add_vec(4,    1,   2,   3,   4,    1,   1,   1,   1, 0,0,0,   5, 0, 0,   10);
    add_vec(4,  127, 127, 127, 127,  127, 127, 127, 127, 0,0,0,   1, 0, 0,  127);
    add_vec(4, -128,-128,-128,-128,  127, 127, 127, 127, 0,0,0,   2, 0, 0, -128);
    add_vec(4, -128,-128,-128,-128,  127, 127, 127, 127, 0,0,0,   3, 1, 0,    0);
    add_vec(4,   10,  20,  30,  40,    1,   1,   1,   1, 0,0,0,   4, 0, 2,   25);
    add_vec(4,    1,   2,   3,   4,    1,   1,   1,   1, 1,3,0,   5, 0, 0,   10);
    add_vec(1,   -7,   0,   0,   0,    3,   0,   0,   0, 0,0,0,   6, 0, 1,  -11);
    add_vec(2,   50,  50,   0,   0,    3,   3,   0,   0, 0,0,0,   8, 1, 1,  127);
    add_vec(1,   -1,   0,   0,   0,    1,   0,   0,   0, 0,0,0, 255, 0, 0,   -1);
    add_vec(4, -128,-128,-128,-128, -128,-128,-128,-128, 0,0,0,   9, 0, 9,  127);
    add_vec(4, -128,-128,-128,-128, -128,-128,-128,-128, 0,0,0,  10, 0,10,   64);

    for (int i = 0; i < vecs.size(); i++) begin
      apply_vec(vecs[i], i);
    end

    // Back-to-back windows with no idle cycle between them.
    bus.relu_en = 1'b0; bus.out_shift = 4'd0;
    pulse_start();
    wr_q.delete();
    drive(1'b1, 1'b0, 8'd0, 8'sd1, 8'sd1);
    drive(1'b1, 1'b0, 8'd0, 8'sd2, 8'sd1);
    la = cyc;
    drive(1'b1, 1'b1, 8'd0, 8'sd3, 8'sd1);
    drive(1'b1, 1'b0, 8'd1, -8'sd1, 8'sd1);
    drive(1'b1, 1'b0, 8'd1, -8'sd1, 8'sd1);
    lb = cyc;
    drive(1'b1, 1'b1, 8'd1, -8'sd1, 8'sd1);
    repeat (6) idle();
    check("b2b.nwrites", wr_q.size(), 2);
    if (wr_q.size() == 2) begin
      check("b2b.a_lat", wr_q[0].cyc - la, 3);
      check("b2b.a_addr", int'(wr_q[0].addr), 0);
      check("b2b.a_data", int'(wr_q[0].data), 6);
      check("b2b.b_lat", wr_q[1].cyc - lb, 3);
      check("b2b.b_addr", int'(wr_q[1].addr), 1);
      check("b2b.b_data", int'(wr_q[1].data), -3);
    end
    check("b2b.count", int'(bus.rslt_count), 2);

    // Single-tap windows back to back: writes on consecutive cycles.
    pulse_start();
    wr_q.delete();
    la = cyc;
    drive(1'b1, 1'b1, 8'd10, 8'sd2, 8'sd3);
    drive(1'b1, 1'b1, 8'd11, -8'sd4, 8'sd5);
    drive(1'b1, 1'b1, 8'd12, 8'sd1, 8'sd1);
    repeat (5) idle();
    check("single.nwrites", wr_q.size(), 3);
    if (wr_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("single%0d.lat", i), wr_q[i].cyc - la, 3 + i);
        check($sformatf("single%0d.addr", i), int'(wr_q[i].addr), 10 + i);
        check($sformatf("single%0d.count", i), int'(wr_q[i].cnt), 1 + i);
      end
      check("single0.data", int'(wr_q[0].data), 6);
      check("single1.data", int'(wr_q[1].data), -20);
      check("single2.data", int'(wr_q[2].data), 1);
    end

    // Abort a partial window with reset (mode 0) or start (mode 1), then a clean window.
    for (int mode = 0; mode < 2; mode++) begin
      pulse_start();
      drive(1'b1, 1'b0, 8'd9, 8'sd5, 8'sd5);
      wr_q.delete();
      drive(1'b1, 1'b0, 8'd9, 8'sd5, 8'sd5);
      if (mode == 0) reset = 1'b1;
      else bus.start = 1'b1;
      drive(mode == 1, 1'b0, 8'd9, 8'sd9, 8'sd9);
      reset = 1'b0;
      bus.start = 1'b0;
      drive(1'b1, 1'b0, 8'd7, 8'sd1, 8'sd1);
      drive(1'b1, 1'b0, 8'd7, 8'sd1, 8'sd1);
      la = cyc;
      drive(1'b1, 1'b1, 8'd7, 8'sd1, 8'sd1);
      repeat (6) idle();
      check($sformatf("abort%0d.nwrites", mode), wr_q.size(), 1);
      if (wr_q.size() > 0) begin
        check($sformatf("abort%0d.lat", mode), wr_q[0].cyc - la, 3);
        check($sformatf("abort%0d.addr", mode), int'(wr_q[0].addr), 7);
        check($sformatf("abort%0d.data", mode), int'(wr_q[0].data), 3);
        check($sformatf("abort%0d.count", mode), int'(wr_q[0].cnt), 1);
      end
      check($sformatf("abort%0d.busy", mode), int'(bus.busy), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
